// File: rtl/key_conditioner_pkg.sv
// Shared types and constants for the push-button conditioner.
// Default cycle counts assume a 50 MHz system clock.
package key_conditioner_pkg;

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_WAIT,
    HELD,
    REPEATING,
    RELEASE_WAIT
  } key_state_e;

  localparam int DEFAULT_DEBOUNCE_CYCLES     = 1_000_000;
  localparam int DEFAULT_REPEAT_DELAY_CYCLES = 25_000_000;
  localparam int DEFAULT_REPEAT_RATE_CYCLES  = 5_000_000;

  // The counter only has to reach (largest cycle count - 1).
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// One key: 2-FF synchronizer, debounce counter and press/release FSM.
// Define KEY_CONDITIONER_AUTOREPEAT_EN to add repeat pulses while a key is held.
module key_debounce_fsm
  import key_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pulse,
  output logic level
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);
`endif

  logic [1:0]       sync_q;
  logic             pressed;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             level_q, level_d;

  // Synchronizer resets to "released" so a held key re-debounces after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], key_n};
  end

  assign pressed = ~sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    level_d = level_q;
    unique case (state_q)
      RELEASED: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HELD;
          level_d = 1'b1;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
        end else if (cnt_q == DELAY_LAST) begin
          state_d = REPEATING;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
      REPEATING: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == RATE_LAST) begin
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      RELEASE_WAIT: begin
        // A re-press while releasing is contact bounce: back to HELD, no pulse.
        if (pressed) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = RELEASED;
          level_d = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  assign pulse = pulse_q;
  assign level = level_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the active-low board push-buttons for the NIOS key PIO.
// Auto-repeat is enabled by defining KEY_CONDITIONER_AUTOREPEAT_EN.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int NUM_KEYS            = 3,
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEFAULT_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEFAULT_REPEAT_RATE_CYCLES
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] key_n_i,
  output logic [NUM_KEYS-1:0] key_pulse_o,
  output logic [NUM_KEYS-1:0] key_level_o
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce_fsm #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
    ) u_fsm (
      .clk  (clk_clk),
      .rst  (reset_reset),
      .key_n(key_n_i[g]),
      .pulse(key_pulse_o[g]),
      .level(key_level_o[g])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with short debounce/repeat counts.
// Record i is driven before clock edge i and checked after it.
module tb_key_conditioner;

  typedef struct packed {
    logic [2:0] key_n;
    logic [2:0] pulse;
    logic [2:0] level;
  } vec_t;

  typedef struct packed {
    logic [2:0] pulse;
    logic [2:0] level;
  } exp_t;

  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [2:0] key_n_i;
  logic [2:0] key_pulse_o;
  logic [2:0] key_level_o;

  vec_t vec [64];
  int   vec_len;
  exp_t sb [$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  key_conditioner #(
    .NUM_KEYS           (3),
    .DEBOUNCE_CYCLES    (4),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_RATE_CYCLES (3)
  ) dut (
    .clk_clk    (clk_clk),
    .reset_reset(reset_reset),
    .key_n_i    (key_n_i),
    .key_pulse_o(key_pulse_o),
    .key_level_o(key_level_o)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [2:0] key_n, input logic [2:0] pulse,
                               input logic [2:0] level);
    exp_t e;
    key_n_i = key_n;
    e.pulse = pulse;
    e.level = level;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int idx);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("[TB] FAIL %s[%0d]: scoreboard empty", name, idx);
      return;
    end
    e = sb.pop_front();
    if (key_pulse_o !== e.pulse) begin
      n_fail++;
      $display("[TB] FAIL %s[%0d] pulse: got %b, expected %b", name, idx, key_pulse_o, e.pulse);
    end
    n_cmp++;
    if (key_level_o !== e.level) begin
      n_fail++;
      $display("[TB] FAIL %s[%0d] level: got %b, expected %b", name, idx, key_level_o, e.level);
    end
  endtask

  task automatic clearTable(input int len);
    for (int i = 0; i < len; i++) vec[i] = '{key_n: 3'b111, pulse: 3'b000, level: 3'b000};
    vec_len = len;
  endtask

  task automatic runTable(input string name);
    for (int i = 0; i < vec_len; i++) begin
      applyStimulus(vec[i].key_n, vec[i].pulse, vec[i].level);
      @(negedge clk_clk);
      checkOutput(name, i);
    end
  endtask

  initial begin
    reset_reset = 1'b1;
    key_n_i     = 3'b111;
    @(negedge clk_clk);
    applyStimulus(3'b111, 3'b000, 3'b000);
    @(negedge clk_clk);
    checkOutput("reset_state", 0);
    reset_reset = 1'b0;

    // Clean press on key 0: edge N=2, release at M=22.
    clearTable(32);
    for (int i = 2; i < 22; i++) vec[i].key_n[0] = 1'b0;
    vec[8].pulse[0] = 1'b1;
    for (int i = 8; i < 28; i++) vec[i].level[0] = 1'b1;
    runTable("clean_press");

    // Key 1: 3-cycle glitch, then a press with a 2-cycle bounce on release.
    clearTable(46);
    for (int i = 2; i < 5; i++) vec[i].key_n[1] = 1'b0;
    for (int i = 10; i < 30; i++) vec[i].key_n[1] = 1'b0;
    for (int i = 32; i < 34; i++) vec[i].key_n[1] = 1'b0;
    vec[16].pulse[1] = 1'b1;
    for (int i = 16; i < 40; i++) vec[i].level[1] = 1'b1;
    runTable("glitch_bounce");

    // All keys pressed on the same edge.
    clearTable(22);
    for (int i = 2; i < 12; i++) vec[i].key_n = 3'b000;
    vec[8].pulse = 3'b111;
    for (int i = 8; i < 18; i++) vec[i].level = 3'b111;
    runTable("simultaneous");

    // Key 0 held (level up), key 2 enters PRESS_WAIT, then reset hits.
    clearTable(10);
    for (int i = 0; i < 10; i++) vec[i].key_n[0] = 1'b0;
    for (int i = 7; i < 10; i++) vec[i].key_n[2] = 1'b0;
    vec[6].pulse[0] = 1'b1;
    for (int i = 6; i < 10; i++) vec[i].level[0] = 1'b1;
    runTable("reset_pre");

    reset_reset = 1'b1;
    applyStimulus(3'b010, 3'b000, 3'b000);
    #1;
    checkOutput("reset_async", 0);
    applyStimulus(3'b010, 3'b000, 3'b000);
    @(negedge clk_clk);
    checkOutput("reset_hold", 1);
    reset_reset = 1'b0;

    // Keys still held after reset: exactly one fresh pulse per held key.
    clearTable(20);
    for (int i = 0; i < 12; i++) vec[i].key_n = 3'b010;
    vec[6].pulse = 3'b101;
    for (int i = 6; i < 18; i++) vec[i].level = 3'b101;
    runTable("reset_post");

    // Key 0 held 40 cycles: edge N=2, release M=42.
    clearTable(54);
    for (int i = 2; i < 42; i++) vec[i].key_n[0] = 1'b0;
    vec[8].pulse[0] = 1'b1;
`ifdef KEY_CONDITIONER_AUTOREPEAT_EN
    for (int k = 18; k <= 42; k += 3) vec[k].pulse[0] = 1'b1;
`endif
    for (int i = 8; i < 48; i++) vec[i].level[0] = 1'b1;
    runTable("long_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions the raw active-low push-buttons of the clock board before they reach the NIOS key PIO inputs (key 0/1/2).
- Per key: 2-FF synchronizer, debounce state machine, one-cycle press pulse for PIO edge capture, and a debounced level.
- Optional auto-repeat for fast time setting while a key is held.
- Sits between the board pins and the processor system; one instance serves all keys.

Parameters:
- NUM_KEYS, 3, number of independent keys.
- DEBOUNCE_CYCLES, 1_000_000, stable-sample count for press/release acceptance (20 ms at 50 MHz); must be >= 2.
- REPEAT_DELAY_CYCLES, 25_000_000, hold time before the first repeat pulse (500 ms); must be >= 2.
- REPEAT_RATE_CYCLES, 5_000_000, interval between later repeat pulses (100 ms); must be >= 2.

Ports:
- clk_clk  in  1  system clock (50 MHz).
- reset_reset  in  1  reset; asynchronous, active-high.
- key_n_i  in  NUM_KEYS  raw button pins; 0 = pressed; asynchronous to clk_clk.
- key_pulse_o  out  NUM_KEYS  one-cycle high per accepted press, and per repeat; feeds the PIO edge capture.
- key_level_o  out  NUM_KEYS  debounced state; 1 = pressed.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - synchronizers load 1 (released);
  - all FSMs go to RELEASED and counters clear;
  - key_pulse_o = 0, key_level_o = 0.
- Per-key logic is fully independent. All outputs are registered. "pressed" below means the synchronized key_n_i equals 0.
- Per-key FSM (one counter, width = clog2 of the largest cycle parameter):
  - RELEASED, level 0: if pressed, go to PRESS_WAIT and set cnt = 0.
  - PRESS_WAIT: if released, go to RELEASED (glitch rejected, no pulse). Otherwise, if cnt == DEBOUNCE_CYCLES-1, go to HELD, set level_o = 1, pulse 1 cycle, cnt = 0. Otherwise cnt++.
  - HELD: if released, go to RELEASE_WAIT and set cnt = 0. Otherwise cnt++ (only used with the optional feature).
  - RELEASE_WAIT: if pressed, go to HELD with cnt = 0, no new pulse (bounce on release). If cnt == DEBOUNCE_CYCLES-1, go to RELEASED and set level_o = 0. Otherwise cnt++.
- Latency:
  - Let edge N be the first rising edge that samples key_n_i low, with the key held stable.
  - key_pulse_o and key_level_o rise after edge N+DEBOUNCE_CYCLES+2.
  - Release is symmetric: key_level_o falls after edge M+DEBOUNCE_CYCLES+2.
  - key_pulse_o is never high for two consecutive cycles.
- Boundary conditions:
  - A press shorter than DEBOUNCE_CYCLES synchronized cycles produces no pulse and no level change.
  - Simultaneous presses on several keys yield simultaneous independent pulses.
  - If reset is asserted mid-debounce or while held, all state is lost. A key still held after reset release re-debounces from RELEASED and produces exactly one fresh pulse.
  - Counter never wraps: it is cleared on every state transition, and comparisons use ==.

Optional Feature:
- Macro: KEY_CONDITIONER_AUTOREPEAT_EN.
- Defined: adds a REPEATING state.
  - In HELD, when cnt == REPEAT_DELAY_CYCLES-1: pulse 1 cycle, cnt = 0, go to REPEATING.
  - In REPEATING, when cnt == REPEAT_RATE_CYCLES-1: pulse 1 cycle, cnt = 0.
  - In REPEATING, release goes to RELEASE_WAIT, and a re-press from there returns to HELD (repeat delay restarts).
  - key_level_o stays 1 throughout.
- Undefined: no REPEATING state; HELD holds silently until release; the REPEAT_* parameters are unused; exactly one pulse per accepted press.

Decomposition:
- Package key_conditioner_pkg:
  - state enum (RELEASED, PRESS_WAIT, HELD, REPEATING, RELEASE_WAIT);
  - default cycle constants;
  - function computing counter width.
- Sub-module key_debounce_fsm: one key's synchronizer, counter and FSM. The top generates NUM_KEYS instances and concatenates their outputs.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3.
- Clean press: key_n_i[0] goes 1->0 and is held 20 cycles. key_pulse_o[0] is high exactly 1 cycle, after edge N+6; key_level_o[0]=1 from then on. Keys 1 and 2 stay 0.
- Glitch: key_n_i[1] is low for 3 cycles, then high. No pulse and key_level_o[1] stays 0. Then a bouncy release with a 2-cycle re-press inside RELEASE_WAIT gives no second pulse, and level falls DEBOUNCE_CYCLES+2 edges after the final release.
- Simultaneous: all three keys pressed on the same edge. key_pulse_o = 3'b111 for one cycle, after edge N+6.
- Reset mid-operation: reset_reset is asserted while key 2 is in PRESS_WAIT, and the key is held throughout. Outputs are 0 immediately (async). After reset release, exactly one pulse appears 6 edges after the first sampling edge.
- Autorepeat (with the macro defined): key 0 held 40 cycles gives pulses at the debounce point, +10, then every 3 cycles. Without the macro, the same stimulus gives exactly 1 pulse.
